// File: rtl/ahb_bram_slave.sv
// AHB-Lite zero-wait-state slave for a simple dual-port BRAM (write port A, registered read port B).
// Define AHB_BRAM_FWD_EN to forward write data into a colliding read instead of a one-cycle stall.
module ahb_bram_slave #(
  parameter int unsigned ADDR_WIDTH = 14
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic                  HREADY,
  input  logic [31:0]           HWDATA,
  output logic [31:0]           HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [31:0]           ram_dina,
  output logic [3:0]            ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [31:0]           ram_doutb
);

  localparam int unsigned AW = ADDR_WIDTH;

  logic          accept;
  logic [AW-1:0] haddr_idx;
  logic [3:0]    be;
  logic          hazard;

  logic          wr_pend;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_be;
  logic          rd_pend;
  logic [AW-1:0] rd_addr;

  assign accept    = HSEL & HTRANS[1] & HREADY;
  assign haddr_idx = HADDR[AW+1:2];
  // Read address phase colliding with the write data phase to the same word
  assign hazard    = accept & ~HWRITE & wr_pend & (wr_addr == haddr_idx);

  always_comb begin
    be = 4'b1111;
    case (HSIZE)
      3'd0:    be = 4'b0001 << HADDR[1:0];
      3'd1:    be = HADDR[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_pend <= 1'b0;
      wr_addr <= '0;
      wr_be   <= '0;
      rd_pend <= 1'b0;
      rd_addr <= '0;
    end else begin
      wr_pend <= accept & HWRITE;
      if (accept & HWRITE) begin
        wr_addr <= haddr_idx;
        wr_be   <= be;
      end
      if (HREADY) rd_pend <= accept & ~HWRITE;
      if (accept & ~HWRITE) rd_addr <= haddr_idx;
    end
  end

  assign ram_wea   = wr_pend ? wr_be : 4'b0000;
  assign ram_addra = wr_addr;
  assign ram_dina  = HWDATA;
  assign HRESP     = 1'b0;

`ifdef AHB_BRAM_FWD_EN
  logic        fwd_q;
  logic [3:0]  fwd_be;
  logic [31:0] fwd_data;
  logic        unused_c;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fwd_q    <= 1'b0;
      fwd_be   <= '0;
      fwd_data <= '0;
    end else begin
      fwd_q <= hazard;
      if (hazard) begin
        fwd_be   <= wr_be;
        fwd_data <= HWDATA;
      end
    end
  end

  // Overlay the just-written bytes on the stale RAM word
  always_comb begin
    HRDATA = ram_doutb;
    if (fwd_q & rd_pend) begin
      for (int i = 0; i < 4; i++) begin
        if (fwd_be[i]) HRDATA[8*i +: 8] = fwd_data[8*i +: 8];
      end
    end
  end

  assign HREADYOUT = 1'b1;
  assign ram_addrb = haddr_idx;
  assign unused_c  = ^{HTRANS[0], HADDR[31:AW+2], rd_addr};
`else
  logic ready_q;
  logic unused_c;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) ready_q <= 1'b1;
    else          ready_q <= ~hazard;
  end

  // During the stall re-read the word once the write has landed
  assign HREADYOUT = ready_q;
  assign ram_addrb = (~ready_q & rd_pend) ? rd_addr : haddr_idx;
  assign HRDATA    = ram_doutb;
  assign unused_c  = ^{HTRANS[0], HADDR[31:AW+2]};
`endif

endmodule

// File: tb/tb_ahb_bram_slave.sv
// Self-checking bench for ahb_bram_slave: pipelined AHB driver, BRAM model and a word-array reference.
module tb_ahb_bram_slave;

  localparam int unsigned AW    = 14;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned MAXT  = 64;
`ifdef AHB_BRAM_FWD_EN
  localparam int HAZ_STALL = 0;
`else
  localparam int HAZ_STALL = 1;
`endif

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic          HWRITE;
  logic          HREADY;
  logic [31:0]   HWDATA;
  logic [31:0]   HRDATA;
  logic          HREADYOUT;
  logic          HRESP;
  logic [AW-1:0] ram_addra;
  logic [31:0]   ram_dina;
  logic [3:0]    ram_wea;
  logic [AW-1:0] ram_addrb;
  logic [31:0]   ram_doutb;

  int checks   = 0;
  int failures = 0;

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;

  ahb_bram_slave #(.ADDR_WIDTH(AW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .ram_addra(ram_addra), .ram_dina(ram_dina),
    .ram_wea(ram_wea), .ram_addrb(ram_addrb), .ram_doutb(ram_doutb)
  );

  // Block RAM: byte-enable write, read-first registered read
  logic [31:0] mem [DEPTH];
  always @(posedge HCLK) begin
    for (int k = 0; k < 4; k++) if (ram_wea[k]) mem[ram_addra][8*k +: 8] <= ram_dina[8*k +: 8];
    ram_doutb <= mem[ram_addrb];
  end

  // Reference: memory as words, each bus write applied in order when its data is on the bus
  logic [31:0] ref_mem [DEPTH];

  typedef struct packed {
    logic        sel;
    logic [1:0]  trans;
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
  } txn_t;
  txn_t q[$];

  logic [31:0]   obs_rdata [MAXT], exp_rdata [MAXT];
  logic [3:0]    obs_wea   [MAXT], exp_wea   [MAXT];
  logic [AW-1:0] obs_addra [MAXT];
  logic [31:0]   obs_dina  [MAXT], exp_dina  [MAXT];
  int            obs_stall [MAXT], exp_stall [MAXT];
  logic          is_rd     [MAXT];

  function automatic int unsigned widx(logic [31:0] a);
    return 32'(a[AW+1:2]);
  endfunction

  function automatic logic [3:0] be_of(logic [31:0] a, logic [2:0] s);
    int nb, st;
    logic [3:0] m;
    nb = (s == 3'd0) ? 1 : (s == 3'd1) ? 2 : 4;
    st = (32'(a[1:0]) / nb) * nb;
    m  = '0;
    for (int k = 0; k < 4; k++) if (k >= st && k < st + nb) m[k] = 1'b1;
    return m;
  endfunction

  function automatic void model_write(logic [31:0] a, logic [2:0] s, logic [31:0] d);
    logic [3:0] m;
    m = be_of(a, s);
    for (int k = 0; k < 4; k++) if (m[k]) ref_mem[widx(a)][8*k +: 8] = d[8*k +: 8];
  endfunction

  function automatic void add(logic sel, logic [1:0] tr, logic wr, logic [31:0] a, logic [2:0] s, logic [31:0] d);
    txn_t t;
    t.sel = sel; t.trans = tr; t.write = wr; t.addr = a; t.size = s; t.data = d;
    q.push_back(t);
  endfunction

  // Drives q as a pipelined AHB master and records what each transfer's data phase looked like
  task automatic run_seq();
    int   n, dp_idx, stalls;
    logic dp_wr, dp_haz, act;
    txn_t dp, t;
    n = q.size();
    dp_wr = 1'b0; dp_haz = 1'b0; dp = '0; dp_idx = -1;
    for (int i = 0; i <= n; i++) begin
      t = (i < n) ? q[i] : '0;
      act = t.sel & t.trans[1];
      HSEL = t.sel; HTRANS = t.trans; HWRITE = t.write; HADDR = t.addr; HSIZE = t.size;
      HWDATA = dp_wr ? dp.data : $urandom;
      @(negedge HCLK);
      if (dp_idx >= 0) begin
        obs_wea[dp_idx]   = ram_wea;
        obs_addra[dp_idx] = ram_addra;
        obs_dina[dp_idx]  = ram_dina;
        exp_wea[dp_idx]   = dp_wr ? be_of(dp.addr, dp.size) : 4'h0;
        exp_dina[dp_idx]  = dp.data;
        if (dp_wr) model_write(dp.addr, dp.size, dp.data);
      end
      stalls = 0;
      while (HREADYOUT !== 1'b1 && stalls < 4) begin
        stalls++;
        @(negedge HCLK);
      end
      if (dp_idx >= 0) begin
        obs_stall[dp_idx] = stalls;
        exp_stall[dp_idx] = dp_haz ? HAZ_STALL : 0;
        obs_rdata[dp_idx] = HRDATA;
        exp_rdata[dp_idx] = ref_mem[widx(dp.addr)];
      end
      if (i < n) begin
        dp_haz    = act & ~t.write & dp_wr & (widx(t.addr) == widx(dp.addr));
        dp_wr     = act & t.write;
        is_rd[i]  = act & ~t.write;
        dp        = t;
        dp_idx    = i;
      end else begin
        dp_idx = -1;
      end
      @(posedge HCLK); #1;
    end
    q.delete();
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0; HSIZE = 3'd2; HWDATA = '0;
    repeat (2) @(posedge HCLK); #1;
    checks++; if (HREADYOUT !== 1'b1) begin failures++; $display("FAIL reset_hreadyout got=%b exp=1", HREADYOUT); end
    checks++; if (HRESP !== 1'b0) begin failures++; $display("FAIL reset_hresp got=%b exp=0", HRESP); end
    checks++; if (ram_wea !== 4'h0) begin failures++; $display("FAIL reset_wea got=%h exp=0", ram_wea); end
    HRESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      checks++; if (ram_wea !== 4'h0) begin failures++; $display("FAIL idle_wea got=%h exp=0", ram_wea); end
    end
    @(posedge HCLK); #1;
  endtask

  task automatic test_init();
    for (int w = 0; w < 32; w++) add(1'b1, 2'b10, 1'b1, 32'(w * 4), 3'd2, $urandom);
    run_seq();
    for (int w = 0; w < 32; w++) begin
      checks++;
      if (obs_wea[w] !== 4'hF || obs_addra[w] !== AW'(w)) begin
        failures++; $display("FAIL init_write[%0d] got wea=%h addra=%0d exp wea=f addra=%0d", w, obs_wea[w], obs_addra[w], w);
      end
    end
  endtask

  task automatic test_word();
    add(1'b1, 2'b10, 1'b1, 32'h20, 3'd2, 32'hDEADBEEF);
    add(1'b0, 2'b00, 1'b0, 32'h0, 3'd2, 32'h0);
    add(1'b1, 2'b10, 1'b0, 32'h20, 3'd2, 32'h0);
    run_seq();
    checks++; if (obs_wea[0] !== 4'hF) begin failures++; $display("FAIL word_wea got=%h exp=f", obs_wea[0]); end
    checks++; if (obs_addra[0] !== AW'(8)) begin failures++; $display("FAIL word_addra got=%0d exp=8", obs_addra[0]); end
    checks++; if (obs_dina[0] !== exp_dina[0]) begin failures++; $display("FAIL word_dina got=%h exp=%h", obs_dina[0], exp_dina[0]); end
    checks++; if (obs_rdata[2] !== 32'hDEADBEEF) begin failures++; $display("FAIL word_rdata got=%h exp=deadbeef", obs_rdata[2]); end
    checks++; if (obs_stall[2] !== 0) begin failures++; $display("FAIL word_stall got=%0d exp=0", obs_stall[2]); end
  endtask

  task automatic test_subword();
    add(1'b1, 2'b10, 1'b1, 32'h23, 3'd0, 32'h000000AA);
    add(1'b1, 2'b11, 1'b1, 32'h26, 3'd1, 32'h55660000);
    add(1'b0, 2'b00, 1'b0, 32'h0, 3'd2, 32'h0);
    add(1'b1, 2'b10, 1'b0, 32'h20, 3'd2, 32'h0);
    add(1'b1, 2'b11, 1'b0, 32'h24, 3'd2, 32'h0);
    run_seq();
    checks++; if (obs_wea[0] !== 4'b1000 || obs_addra[0] !== AW'(8)) begin
      failures++; $display("FAIL byte_wea got wea=%b addra=%0d exp wea=1000 addra=8", obs_wea[0], obs_addra[0]); end
    checks++; if (obs_wea[1] !== 4'b1100 || obs_addra[1] !== AW'(9)) begin
      failures++; $display("FAIL half_wea got wea=%b addra=%0d exp wea=1100 addra=9", obs_wea[1], obs_addra[1]); end
    checks++; if (obs_rdata[3] !== 32'h00ADBEEF) begin failures++; $display("FAIL byte_rdata got=%h exp=00adbeef", obs_rdata[3]); end
    checks++; if (obs_rdata[4] !== exp_rdata[4]) begin failures++; $display("FAIL half_rdata got=%h exp=%h", obs_rdata[4], exp_rdata[4]); end
  endtask

  task automatic test_hazard();
    add(1'b1, 2'b10, 1'b1, 32'h40, 3'd2, 32'h11111111);
    add(1'b0, 2'b00, 1'b0, 32'h0, 3'd2, 32'h0);
    add(1'b1, 2'b10, 1'b1, 32'h40, 3'd1, 32'h0000BEEF);
    add(1'b1, 2'b10, 1'b0, 32'h40, 3'd2, 32'h0);
    run_seq();
    checks++; if (obs_rdata[3] !== 32'h1111BEEF) begin failures++; $display("FAIL hazard_rdata got=%h exp=1111beef", obs_rdata[3]); end
    checks++; if (obs_stall[3] !== HAZ_STALL) begin failures++; $display("FAIL hazard_stall got=%0d exp=%0d", obs_stall[3], HAZ_STALL); end
    checks++; if (obs_wea[2] !== 4'b0011) begin failures++; $display("FAIL hazard_wea got=%b exp=0011", obs_wea[2]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    add(1'b1, 2'b10, 1'b1, 32'h10, 3'd2, a);
    add(1'b1, 2'b11, 1'b1, 32'h14, 3'd2, b);
    add(1'b1, 2'b10, 1'b0, 32'h14, 3'd2, 32'h0);
    add(1'b1, 2'b11, 1'b0, 32'h10, 3'd2, 32'h0);
    run_seq();
    checks++; if (obs_rdata[2] !== b) begin failures++; $display("FAIL b2b_rd14 got=%h exp=%h", obs_rdata[2], b); end
    checks++; if (obs_rdata[3] !== a) begin failures++; $display("FAIL b2b_rd10 got=%h exp=%h", obs_rdata[3], a); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_stall[i] !== exp_stall[i]) begin
        failures++; $display("FAIL b2b_stall[%0d] got=%0d exp=%0d", i, obs_stall[i], exp_stall[i]);
      end
    end
  endtask

  task automatic test_ignored();
    logic [31:0] old;
    old = ref_mem[18];
    add(1'b0, 2'b10, 1'b1, 32'h48, 3'd2, 32'h12345678);
    add(1'b1, 2'b01, 1'b1, 32'h48, 3'd2, 32'h9ABCDEF0);
    add(1'b1, 2'b00, 1'b1, 32'h48, 3'd2, 32'h0F0F0F0F);
    add(1'b1, 2'b10, 1'b0, 32'h48, 3'd2, 32'h0);
    run_seq();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_wea[i] !== 4'h0) begin failures++; $display("FAIL ignored_wea[%0d] got=%h exp=0", i, obs_wea[i]); end
    end
    checks++; if (obs_rdata[3] !== old) begin failures++; $display("FAIL ignored_rdata got=%h exp=%h", obs_rdata[3], old); end
  endtask

  task automatic test_random();
    int n;
    n = 48;
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      int r;
      a = $urandom;
      a[AW+1:2] = AW'($urandom_range(0, 7));
      r = $urandom_range(0, 9);
      add(r != 0, (r == 1) ? 2'b01 : (r == 2) ? 2'b00 : (r < 6) ? 2'b10 : 2'b11,
          $urandom_range(0, 1) == 1, a, 3'($urandom_range(0, 3)), $urandom);
    end
    run_seq();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_wea[i] !== exp_wea[i] || obs_stall[i] !== exp_stall[i] ||
          (is_rd[i] && obs_rdata[i] !== exp_rdata[i])) begin
        failures++;
        $display("FAIL random[%0d] got wea=%h stall=%0d rdata=%h exp wea=%h stall=%0d rdata=%h rd=%b",
                 i, obs_wea[i], obs_stall[i], obs_rdata[i], exp_wea[i], exp_stall[i], exp_rdata[i], is_rd[i]);
      end
    end
    checks++; if (HRESP !== 1'b0) begin failures++; $display("FAIL random_hresp got=%b exp=0", HRESP); end
  endtask

  task automatic test_reset_mid_write();
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h60; HSIZE = 3'd2; HWDATA = $urandom;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'hCAFEF00D;
    #1;
    checks++; if (ram_wea !== 4'hF) begin failures++; $display("FAIL rst_pre_wea got=%h exp=f", ram_wea); end
    HRESETn = 1'b0;
    #1;
    checks++; if (ram_wea !== 4'h0) begin failures++; $display("FAIL rst_mid_wea got=%h exp=0", ram_wea); end
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    add(1'b1, 2'b10, 1'b0, 32'h60, 3'd2, 32'h0);
    run_seq();
    checks++; if (obs_rdata[0] !== ref_mem[24]) begin failures++; $display("FAIL rst_rdata got=%h exp=%h", obs_rdata[0], ref_mem[24]); end
  endtask

  task automatic test_mem_contents();
    for (int w = 0; w < 32; w++) begin
      checks++;
      if (mem[w] !== ref_mem[w]) begin failures++; $display("FAIL mem[%0d] got=%h exp=%h", w, mem[w], ref_mem[w]); end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_word();
    test_subword();
    test_hazard();
    test_back_to_back();
    test_ignored();
    test_random();
    test_reset_mid_write();
    test_mem_contents();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
